// File: rtl/pe_result_serializer.sv
// pe_result_serializer
// Captures the packed pe_array result word into a 2-entry ping-pong store and
// streams it out one lane per beat (lane 0 first) over valid/ready. A capture
// that finds both entries occupied is dropped and recorded in a sticky flag.
module pe_result_serializer #(
    parameter int ARRAY_NUM = 3,
    parameter int DATA_W    = 8
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iResultValid,
    input  logic [DATA_W*ARRAY_NUM-1:0] iResult,
    output logic                        oCaptureReady,
    output logic [DATA_W-1:0]           oData,
    output logic                        oValid,
    input  logic                        iReady,
    output logic                        oLast,
    output logic                        oOverflow,
    input  logic                        iClearOverflow
);

    localparam int RESULT_W = DATA_W * ARRAY_NUM;
    localparam int LANE_W   = (ARRAY_NUM > 1) ? $clog2(ARRAY_NUM) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(ARRAY_NUM - 1);

    // The FSM state is the occupancy of the store: 0, 1 or 2 entries.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN_ONE  = 2'd1,
        DRAIN_FULL = 2'd2
    } state_e;

    state_e                state_q, state_d;

    logic [RESULT_W-1:0]   entry_q [2];
    logic [RESULT_W-1:0]   entry_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic                  overflow_q, overflow_d;

    // ------------------------------------------------------------------
    // Handshake decode, all taken from register state before the edge.
    // ------------------------------------------------------------------
    logic head_valid;
    logic at_last_lane;
    logic do_capture;
    logic do_drop;
    logic beat;
    logic pop;

    // A capture is judged only on the occupancy before the edge, so a full
    // store drops it even if the head entry finishes draining this cycle.
    assign head_valid   = (state_q != IDLE);
    assign at_last_lane = (lane_q == LAST_LANE);
    assign do_capture   = iResultValid && (state_q != DRAIN_FULL);
    assign do_drop      = iResultValid && (state_q == DRAIN_FULL);
    assign beat         = head_valid && iReady;
    assign pop          = beat && at_last_lane;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------

    // Occupancy state register.
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (iRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------

    // Occupancy moves up on capture and down on the final-lane pop; both
    // together leave it unchanged.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of
        // inferred latches on any path that does not change the state.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (do_capture) begin
                    state_d = DRAIN_ONE;
                end
            end
            DRAIN_ONE: begin
                if (do_capture && !pop) begin
                    state_d = DRAIN_FULL;
                end else if (!do_capture && pop) begin
                    state_d = IDLE;
                end
            end
            DRAIN_FULL: begin
                if (pop) begin
                    state_d = DRAIN_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------

    // Stream outputs come straight from registers; oData is zeroed when empty.
    always_comb begin
        oValid        = head_valid;
        oLast         = head_valid && at_last_lane;
        oCaptureReady = (state_q != DRAIN_FULL);
        oData         = '0;
        if (head_valid) begin
            oData = entry_q[rd_ptr_q][DATA_W*lane_q +: DATA_W];
        end
    end

    assign oOverflow = overflow_q;

    // ------------------------------------------------------------------
    // Datapath: store, pointers, lane index, overflow flag
    // ------------------------------------------------------------------

    // Next values for the store and its bookkeeping.
    always_comb begin
        entry_d    = entry_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lane_d     = lane_q;
        overflow_d = overflow_q;

        // iResult is only looked at when it is actually written.
        if (do_capture) begin
            entry_d[wr_ptr_q] = iResult;
            wr_ptr_d          = ~wr_ptr_q;
        end

        // The lane index holds under backpressure and wraps to lane 0 as the
        // head entry retires, so the next entry starts without a bubble.
        if (beat) begin
            if (at_last_lane) begin
                lane_d   = '0;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end

        // A drop in the same cycle as a clear must still be visible, so the
        // set is applied last.
        if (iClearOverflow) begin
            overflow_d = 1'b0;
        end
        if (do_drop) begin
            overflow_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            // NOTE: the store is cleared on reset so no stale result can ever
            // be replayed after a mid-stream reset; it is only two words.
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            lane_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_q     <= lane_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_pe_result_serializer.sv
// Directed bench for pe_result_serializer: inputs change 1 time unit after a
// rising edge and outputs are checked at that same point, i.e. they reflect
// the register state left by the edge just taken.
module tb_pe_result_serializer;

    localparam int ARRAY_NUM = 3;
    localparam int DATA_W    = 8;

    logic                        iClk = 1'b0;
    logic                        iRst;
    logic                        iResultValid;
    logic [DATA_W*ARRAY_NUM-1:0] iResult;
    logic                        oCaptureReady;
    logic [DATA_W-1:0]           oData;
    logic                        oValid;
    logic                        iReady;
    logic                        oLast;
    logic                        oOverflow;
    logic                        iClearOverflow;

    int vectors    = 0;
    int miscompares = 0;

    pe_result_serializer #(
        .ARRAY_NUM(ARRAY_NUM),
        .DATA_W   (DATA_W)
    ) dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iResultValid  (iResultValid),
        .iResult       (iResult),
        .oCaptureReady (oCaptureReady),
        .oData         (oData),
        .oValid        (oValid),
        .iReady        (iReady),
        .oLast         (oLast),
        .oOverflow     (oOverflow),
        .iClearOverflow(iClearOverflow)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [7:0] data, input logic last);
        check({tag, ".valid"}, 32'(oValid), 32'd1);
        check({tag, ".data"},  32'(oData),  32'(data));
        check({tag, ".last"},  32'(oLast),  32'(last));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(oValid), 32'd0);
        check({tag, ".data"},  32'(oData),  32'd0);
        check({tag, ".last"},  32'(oLast),  32'd0);
    endtask

    initial begin
        iRst           = 1'b1;
        iResultValid   = 1'b0;
        iResult        = '0;
        iReady         = 1'b0;
        iClearOverflow = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        expect_idle("reset");
        check("reset.capready", 32'(oCaptureReady), 32'd1);
        check("reset.overflow", 32'(oOverflow), 32'd0);
        iRst = 1'b0;

        // ---------------- single result ----------------
        iReady       = 1'b1;
        iResultValid = 1'b1;
        iResult      = {8'd30, 8'd20, 8'd10};
        tick();
        iResultValid = 1'b0;
        iResult      = '1;
        expect_beat("single.b0", 8'd10, 1'b0);
        tick();
        expect_beat("single.b1", 8'd20, 1'b0);
        tick();
        expect_beat("single.b2", 8'd30, 1'b1);
        tick();
        expect_idle("single.after");

        // ---------------- backpressure on lane 1 ----------------
        iResultValid = 1'b1;
        iResult      = {8'd30, 8'd20, 8'd10};
        tick();
        iResultValid = 1'b0;
        expect_beat("bp.b0", 8'd10, 1'b0);
        tick();
        expect_beat("bp.b1", 8'd20, 1'b0);
        iReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_beat("bp.hold", 8'd20, 1'b0);
        end
        iReady = 1'b1;
        tick();
        expect_beat("bp.b2", 8'd30, 1'b1);
        tick();
        expect_idle("bp.after");

        // ---------------- ping-pong, second capture on the final pop ----------------
        iResultValid = 1'b1;
        iResult      = {8'd3, 8'd2, 8'd1};
        tick();
        iResultValid = 1'b0;
        expect_beat("pp.b1", 8'd1, 1'b0);
        check("pp.capready1", 32'(oCaptureReady), 32'd1);
        tick();
        expect_beat("pp.b2", 8'd2, 1'b0);
        check("pp.capready2", 32'(oCaptureReady), 32'd1);
        tick();
        expect_beat("pp.b3", 8'd3, 1'b1);
        iResultValid = 1'b1;
        iResult      = {8'd6, 8'd5, 8'd4};
        tick();
        iResultValid = 1'b0;
        expect_beat("pp.b4", 8'd4, 1'b0);
        check("pp.capready4", 32'(oCaptureReady), 32'd1);
        tick();
        expect_beat("pp.b5", 8'd5, 1'b0);
        tick();
        expect_beat("pp.b6", 8'd6, 1'b1);
        check("pp.capready6", 32'(oCaptureReady), 32'd1);
        tick();
        expect_idle("pp.after");

        // ---------------- simultaneous capture and final pop ----------------
        iResultValid = 1'b1;
        iResult      = {8'h33, 8'h22, 8'h11};
        tick();
        iResultValid = 1'b0;
        expect_beat("sim.x0", 8'h11, 1'b0);
        tick();
        expect_beat("sim.x1", 8'h22, 1'b0);
        tick();
        expect_beat("sim.x2", 8'h33, 1'b1);
        iResultValid = 1'b1;
        iResult      = {8'd9, 8'd8, 8'd7};
        tick();
        iResultValid = 1'b0;
        expect_beat("sim.y0", 8'd7, 1'b0);
        check("sim.capready", 32'(oCaptureReady), 32'd1);
        tick();
        expect_beat("sim.y1", 8'd8, 1'b0);
        tick();
        expect_beat("sim.y2", 8'd9, 1'b1);
        tick();
        expect_idle("sim.after");

        // ---------------- capture alongside a non-last pop fills the store ----------------
        iResultValid = 1'b1;
        iResult      = {8'hC3, 8'hC2, 8'hC1};
        tick();
        expect_beat("nl.c1", 8'hC1, 1'b0);
        iResult      = {8'hD3, 8'hD2, 8'hD1};
        tick();
        iResultValid = 1'b0;
        expect_beat("nl.c2", 8'hC2, 1'b0);
        check("nl.capready_full", 32'(oCaptureReady), 32'd0);
        tick();
        expect_beat("nl.c3", 8'hC3, 1'b1);
        tick();
        expect_beat("nl.d1", 8'hD1, 1'b0);
        check("nl.capready_one", 32'(oCaptureReady), 32'd1);
        tick();
        expect_beat("nl.d2", 8'hD2, 1'b0);
        tick();
        expect_beat("nl.d3", 8'hD3, 1'b1);
        tick();
        expect_idle("nl.after");

        // ---------------- overflow ----------------
        iReady       = 1'b0;
        iResultValid = 1'b1;
        iResult      = {8'hA2, 8'hA1, 8'hA0};
        tick();
        check("ov.capready_a", 32'(oCaptureReady), 32'd1);
        iResult = {8'hB2, 8'hB1, 8'hB0};
        tick();
        check("ov.capready_b", 32'(oCaptureReady), 32'd0);
        check("ov.flag_b", 32'(oOverflow), 32'd0);
        iResult = {8'hC2, 8'hC1, 8'hC0};
        tick();
        iResultValid = 1'b0;
        check("ov.flag_c", 32'(oOverflow), 32'd1);
        expect_beat("ov.head", 8'hA0, 1'b0);
        // Clear alone while still full.
        iClearOverflow = 1'b1;
        tick();
        check("ov.cleared", 32'(oOverflow), 32'd0);
        // Drop and clear together: set wins.
        iResultValid = 1'b1;
        iResult      = {8'hE2, 8'hE1, 8'hE0};
        tick();
        iResultValid   = 1'b0;
        iClearOverflow = 1'b0;
        check("ov.set_wins", 32'(oOverflow), 32'd1);
        iReady = 1'b1;
        tick();
        expect_beat("ov.a1", 8'hA1, 1'b0);
        tick();
        expect_beat("ov.a2", 8'hA2, 1'b1);
        tick();
        expect_beat("ov.b0", 8'hB0, 1'b0);
        tick();
        expect_beat("ov.b1", 8'hB1, 1'b0);
        tick();
        expect_beat("ov.b2", 8'hB2, 1'b1);
        tick();
        expect_idle("ov.after");
        check("ov.sticky", 32'(oOverflow), 32'd1);
        iClearOverflow = 1'b1;
        tick();
        iClearOverflow = 1'b0;
        check("ov.final_clear", 32'(oOverflow), 32'd0);

        // ---------------- reset mid-drain ----------------
        iReady       = 1'b0;
        iResultValid = 1'b1;
        iResult      = {8'h63, 8'h62, 8'h61};
        tick();
        iResult = {8'h66, 8'h65, 8'h64};
        tick();
        iResult = {8'h69, 8'h68, 8'h67};
        tick();
        iResultValid = 1'b0;
        check("rst.pre_overflow", 32'(oOverflow), 32'd1);
        iReady = 1'b1;
        tick();
        expect_beat("rst.pre_lane1", 8'h62, 1'b0);
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        expect_idle("rst.post");
        check("rst.capready", 32'(oCaptureReady), 32'd1);
        check("rst.overflow", 32'(oOverflow), 32'd0);
        tick();
        expect_idle("rst.stays_empty");
        iResultValid = 1'b1;
        iResult      = {8'h73, 8'h72, 8'h71};
        tick();
        iResultValid = 1'b0;
        expect_beat("rst.n0", 8'h71, 1'b0);
        tick();
        expect_beat("rst.n1", 8'h72, 1'b0);
        tick();
        expect_beat("rst.n2", 8'h73, 1'b1);
        tick();
        expect_idle("rst.after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
